// File: rtl/ext_sram_pipe.sv
// ----------------------------------------------------------------------------
// ext_sram_pipe
//
// Behavioural model of a pipelined external SRAM with one write port (W0)
// and one read port (R0), both using a valid/ready handshake. Writes use
// byte masks. Reads return on R0_data with an R0_rvalid pulse exactly RD_LAT
// cycles after acceptance. The return path has no backpressure. An optional
// periodic stall drops both readies for one cycle out of every STALL_PERIOD
// cycles.
//
// Parameters
//   ADDR_W        word-address width
//   DATA_W        data width (multiple of 8)
//   DEPTH         number of implemented words (<= 2**ADDR_W)
//   RD_LAT        read latency in cycles, 1..8
//   STALL_PERIOD  ready-drop period, 0 = never stall
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   W0_valid/ready           write handshake
//   W0_addr/data/mask        write word address, data, byte strobes
//   R0_valid/ready           read handshake
//   R0_addr                  read word address
//   R0_rvalid/R0_data        read return pulse and data (data held between pulses)
//   oob_err                  sticky flag: some access hit an address >= DEPTH
//   wr_cnt/rd_cnt            wrapping counts of accepted writes/reads
// ----------------------------------------------------------------------------
module ext_sram_pipe #(
    parameter int          ADDR_W       = 26,
    parameter int          DATA_W       = 32,
    parameter int unsigned DEPTH        = 2**ADDR_W,
    parameter int          RD_LAT       = 1,
    parameter int          STALL_PERIOD = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                W0_valid,
    output logic                W0_ready,
    input  logic [ADDR_W-1:0]   W0_addr,
    input  logic [DATA_W-1:0]   W0_data,
    input  logic [DATA_W/8-1:0] W0_mask,
    input  logic                R0_valid,
    output logic                R0_ready,
    input  logic [ADDR_W-1:0]   R0_addr,
    output logic                R0_rvalid,
    output logic [DATA_W-1:0]   R0_data,
    output logic                oob_err,
    output logic [31:0]         wr_cnt,
    output logic [31:0]         rd_cnt
);

    localparam int              NB         = DATA_W / 8;
    localparam int              IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so that DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_L    = (ADDR_W+1)'(DEPTH);
    localparam logic [7:0]      STALL_LAST = (STALL_PERIOD > 0) ? 8'(STALL_PERIOD - 1) : 8'd0;

    // ------------------------------------------------------------------
    // Ready generation: rdy_en holds the readies low until the first edge
    // after reset release. The stall counter then blanks one cycle per period.
    // ------------------------------------------------------------------
    logic [7:0] stall_cnt;
    logic       rdy_en;
    logic       stall_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 8'd0;
            rdy_en    <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (STALL_PERIOD != 0) begin
                stall_cnt <= (stall_cnt == STALL_LAST) ? 8'd0 : stall_cnt + 8'd1;
            end
        end
    end

    assign stall_now = (STALL_PERIOD != 0) && (stall_cnt == STALL_LAST);
    assign W0_ready  = rdy_en && !stall_now;
    assign R0_ready  = rdy_en && !stall_now;

    // ------------------------------------------------------------------
    // Handshakes and address decode
    // ------------------------------------------------------------------
    logic             wr_fire;
    logic             rd_fire;
    logic             wr_in_range;
    logic             rd_in_range;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    assign wr_fire     = W0_valid && W0_ready;
    assign rd_fire     = R0_valid && R0_ready;
    assign wr_in_range = {1'b0, W0_addr} < DEPTH_L;
    assign rd_in_range = {1'b0, R0_addr} < DEPTH_L;
    assign wr_idx      = W0_addr[IDX_W-1:0];
    assign rd_idx      = R0_addr[IDX_W-1:0];

    // ------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------
    // NOTE: the array deliberately has no reset branch: contents (including a
    // preload) survive reset, and a memory without reset maps onto RAM macros.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_fire && wr_in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (W0_mask[b]) begin
                    mem[wr_idx][b*8 +: 8] <= W0_data[b*8 +: 8];
                end
            end
        end
    end

    // Out-of-range reads return zero rather than aliasing onto a real word.
    logic [DATA_W-1:0] rd_word;
    assign rd_word = rd_in_range ? mem[rd_idx] : '0;

    // ------------------------------------------------------------------
    // Read return pipeline: RD_LAT stages, the last one drives the outputs.
    // A stage loads data only when a valid read moves into it. This keeps
    // R0_data holding the last returned word between pulses.
    // ------------------------------------------------------------------
    logic [RD_LAT-1:0] pipe_vld;
    logic [DATA_W-1:0] pipe_data [RD_LAT];

    // NOTE: non-blocking assignments matter here: stage 0 samples rd_word
    // from the array as it stood before this edge's write lands, so a read
    // and a write to the same address on the same edge return the old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_data[k] <= '0;
            end
        end else begin
            pipe_vld[0] <= rd_fire;
            if (rd_fire) begin
                pipe_data[0] <= rd_word;
            end
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                if (pipe_vld[k-1]) begin
                    pipe_data[k] <= pipe_data[k-1];
                end
            end
        end
    end

    assign R0_rvalid = pipe_vld[RD_LAT-1];
    assign R0_data   = pipe_data[RD_LAT-1];

    // ------------------------------------------------------------------
    // Status: transaction counters and sticky out-of-range flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt  <= 32'd0;
            rd_cnt  <= 32'd0;
            oob_err <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
            if (rd_fire) begin
                rd_cnt <= rd_cnt + 32'd1;
            end
            if ((wr_fire && !wr_in_range) || (rd_fire && !rd_in_range)) begin
                oob_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/ext_sram_pipe.md
EXT_SRAM_PIPE -- requirements
Module: ext_sram_pipe

Interface
REQ-001 SHALL have parameter ADDR_W, default 26, meaning word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width, a multiple of 8.
REQ-003 SHALL have parameter DEPTH, default 2**ADDR_W, meaning number of implemented words (DEPTH <= 2**ADDR_W).
REQ-004 SHALL have parameter RD_LAT, default 1, range 1..8, meaning cycles from read acceptance to R0_rvalid.
REQ-005 SHALL have parameter STALL_PERIOD, default 0, range 0..255, meaning ready-drop period (0 means never stall).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; every port is synchronous to its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port W0_valid, input, 1 bit: write request.
REQ-009 SHALL have port W0_ready, output, 1 bit: write accept.
REQ-010 SHALL have port W0_addr, input, ADDR_W bits: write word address.
REQ-011 SHALL have port W0_data, input, DATA_W bits: write data.
REQ-012 SHALL have port W0_mask, input, DATA_W/8 bits: byte strobes; bit i enables byte i.
REQ-013 SHALL have port R0_valid, input, 1 bit: read request.
REQ-014 SHALL have port R0_ready, output, 1 bit: read accept.
REQ-015 SHALL have port R0_addr, input, ADDR_W bits: read word address.
REQ-016 SHALL have port R0_rvalid, output, 1 bit: one-cycle pulse marking valid R0_data.
REQ-017 SHALL have port R0_data, output, DATA_W bits: read data.
REQ-018 SHALL have port oob_err, output, 1 bit: sticky flag for an out-of-range access.
REQ-019 SHALL have port wr_cnt, output, 32 bits: count of accepted writes, wrapping.
REQ-020 SHALL have port rd_cnt, output, 32 bits: count of accepted reads, wrapping.

Function
REQ-021 SHALL accept a write on a clock edge where W0_valid and W0_ready are both high, and update only the masked bytes of mem[W0_addr] on that edge.
REQ-022 SHALL accept a read on a clock edge where R0_valid and R0_ready are both high, and sample mem[R0_addr] on that edge.
REQ-023 SHALL return each accepted read's data on R0_data with R0_rvalid high exactly RD_LAT cycles after acceptance, with no backpressure on the return.
REQ-024 SHALL keep the read return pipeline RD_LAT stages deep, so that one read per cycle sustains full throughput, and SHALL return data in acceptance order.
REQ-025 SHALL hold R0_data at its last returned value while R0_rvalid is low.
REQ-026 SHALL use read-first ordering for a read and a write to the same address accepted on the same edge: the read returns the old data, and a read accepted on a later edge returns the new data.
REQ-027 SHALL apply stall behaviour when STALL_PERIOD = 0: W0_ready and R0_ready are constantly 1.
REQ-028 SHALL apply stall behaviour when STALL_PERIOD = N > 0: an 8-bit stall counter counts 0..N-1 and wraps, and both readies are 0 exactly in the cycle when the counter equals N-1.
REQ-029 SHALL treat an address >= DEPTH as out of range: such a write does not modify the array, such a read returns all-zero data with normal latency, and either sets oob_err on the accepting edge.
REQ-030 SHALL clear oob_err only by reset.
REQ-031 SHALL increment wr_cnt and rd_cnt by one per accepted transaction, wrapping from 0xFFFFFFFF to 0.
REQ-032 SHALL treat W0_mask = 0 as an accepted write that counts in wr_cnt but leaves the array unchanged.

Reset
REQ-033 SHALL, while rst_n is low, drive R0_rvalid=0, R0_data=0, oob_err=0, wr_cnt=0, rd_cnt=0 and stall counter=0, and clear every pipeline valid bit.
REQ-034 SHALL force W0_ready and R0_ready low while rst_n is low, and drive them per REQ-027/028 from the first edge after release.
REQ-035 SHALL discard reads in flight at reset assertion: no R0_rvalid is produced for them after release.
REQ-036 SHALL NOT clear memory array contents on reset, so that a preload placed in the array before or during reset survives.

Verification
REQ-037 SHALL cover this scenario with RD_LAT=3: write 0xDEADBEEF to addr 5 with mask 0xF, then read addr 5 -> R0_rvalid pulses 3 cycles after acceptance with R0_data=0xDEADBEEF.
REQ-038 SHALL cover this scenario: preload mem[9]=0x11223344, write 0xAABBCCDD with mask 0b0101 -> a read of addr 9 returns 0x11BB33DD.
REQ-039 SHALL cover this scenario: a same-edge write of 0x1 and read of addr 7 (old value 0x0) -> the read returns 0x0, and the next-cycle read returns 0x1.
REQ-040 SHALL cover this scenario with STALL_PERIOD=4 and continuous valids for 16 cycles -> readies are low on cycles 3, 7, 11 and 15, and wr_cnt=rd_cnt=12.
REQ-041 SHALL cover this scenario with DEPTH=1024: read of addr 2000 -> data 0 after RD_LAT and oob_err=1; a later in-range access leaves oob_err=1.
REQ-042 SHALL cover this scenario with RD_LAT=4: issue 3 back-to-back reads, then assert rst_n low 2 cycles later -> no R0_rvalid after release, counters are 0, and the array contents are unchanged.
